// File: rtl/cache_axi_line_master.sv
// Cache-line AXI master: moves one cache line per command.
// A fill uses a read burst and a write-back uses a write burst with B-response tracking.
// One command is in flight at a time. The response carries a sticky error flag.
// In WRAP mode the burst starts at the command word (critical word first).
// In INCR mode the burst starts at the line-aligned address.
module cache_axi_line_master #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int BEATS      = 8,
    parameter int WRAP_MODE  = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_store,
    input  logic [ADDR_WIDTH-1:0]         cmd_addr,
    input  logic [DATA_WIDTH*BEATS-1:0]   cmd_wdata,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic                          rsp_store,
    output logic                          rsp_err,
    output logic [DATA_WIDTH*BEATS-1:0]   rsp_rdata,
    output logic [ADDR_WIDTH-1:0]         m_axi_araddr,
    output logic [7:0]                    m_axi_arlen,
    output logic [2:0]                    m_axi_arsize,
    output logic [1:0]                    m_axi_arburst,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [DATA_WIDTH-1:0]         m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rlast,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready,
    output logic [ADDR_WIDTH-1:0]         m_axi_awaddr,
    output logic [7:0]                    m_axi_awlen,
    output logic [2:0]                    m_axi_awsize,
    output logic [1:0]                    m_axi_awburst,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [DATA_WIDTH-1:0]         m_axi_wdata,
    output logic                          m_axi_wlast,
    output logic                          m_axi_wvalid,
    output logic [DATA_WIDTH/8-1:0]       m_axi_wstrb,
    input  logic                          m_axi_wready,
    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready
);

    localparam int BYTE_BITS = $clog2(DATA_WIDTH / 8);
    localparam int IDX_BITS  = $clog2(BEATS);
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] ONES = {ADDR_WIDTH{1'b1}};
    // WRAP keeps the word offset inside the line. INCR also clears the line offset.
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = (WRAP_MODE != 0) ? (ONES << BYTE_BITS)
                                                                   : (ONES << (BYTE_BITS + IDX_BITS));

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_DATA = 3'd4,
        WR_RESP = 3'd5,
        RESP    = 3'd6
    } state_t;

    state_t                               state_q, state_d;
    logic [IDX_BITS-1:0]                  cnt_q, cnt_d;
    logic [IDX_BITS-1:0]                  start_q, start_d;
    logic [ADDR_WIDTH-1:0]                addr_q, addr_d;
    logic [BEATS-1:0][DATA_WIDTH-1:0]     line_q, line_d;
    logic [DATA_WIDTH*BEATS-1:0]          rsp_rdata_q, rsp_rdata_d;
    logic                                 store_q, store_d;
    logic                                 err_q, err_d;
    logic                                 cmd_ready_q, cmd_ready_d;
    logic                                 arvalid_q, arvalid_d;
    logic                                 rready_q, rready_d;
    logic                                 awvalid_q, awvalid_d;
    logic                                 wvalid_q, wvalid_d;
    logic                                 wlast_q, wlast_d;
    logic [DATA_WIDTH-1:0]                wdata_q, wdata_d;
    logic                                 bready_q, bready_d;
    logic                                 rsp_valid_q, rsp_valid_d;
    logic [IDX_BITS-1:0]                  rd_idx_s;
    logic [IDX_BITS-1:0]                  wr_idx_s;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        start_d     = start_q;
        addr_d      = addr_q;
        line_d      = line_q;
        rsp_rdata_d = rsp_rdata_q;
        store_d     = store_q;
        err_d       = err_q;
        rd_idx_s    = start_q + cnt_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d  = cmd_addr & ADDR_MASK;
                    start_d = (WRAP_MODE != 0) ? cmd_addr[BYTE_BITS +: IDX_BITS] : {IDX_BITS{1'b0}};
                    store_d = cmd_store;
                    line_d  = cmd_wdata;
                    err_d   = 1'b0;
                    cnt_d   = {IDX_BITS{1'b0}};
                    state_d = cmd_store ? WR_ADDR : RD_ADDR;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_ADDR: begin
                if (arvalid_q && m_axi_arready) begin
                    state_d = RD_DATA;
                end else begin
                    state_d = RD_ADDR;
                end
            end
            RD_DATA: begin
                if (rready_q && m_axi_rvalid) begin
                    line_d[rd_idx_s] = m_axi_rdata;
                    cnt_d = cnt_q + IDX_BITS'(1);
                    // A bad response or a misplaced or missing RLAST is sticky, and the burst still runs to BEATS.
                    if ((m_axi_rresp != 2'b00) || ((cnt_q == LAST_IDX) != m_axi_rlast)) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    if (cnt_q == LAST_IDX) begin
                        rsp_rdata_d = line_d;
                        state_d     = RESP;
                    end else begin
                        state_d = RD_DATA;
                    end
                end else begin
                    state_d = RD_DATA;
                end
            end
            WR_ADDR: begin
                if (awvalid_q && m_axi_awready) begin
                    state_d = WR_DATA;
                end else begin
                    state_d = WR_ADDR;
                end
            end
            WR_DATA: begin
                if (wvalid_q && m_axi_wready) begin
                    cnt_d = cnt_q + IDX_BITS'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_d = WR_RESP;
                    end else begin
                        state_d = WR_DATA;
                    end
                end else begin
                    state_d = WR_DATA;
                end
            end
            WR_RESP: begin
                if (bready_q && m_axi_bvalid) begin
                    if (m_axi_bresp != 2'b00) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    state_d = RESP;
                end else begin
                    state_d = WR_RESP;
                end
            end
            RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs follow the next state, so each one changes on the same edge as the state does.
        wr_idx_s    = start_d + cnt_d;
        cmd_ready_d = (state_d == IDLE);
        arvalid_d   = (state_d == RD_ADDR);
        rready_d    = (state_d == RD_DATA);
        awvalid_d   = (state_d == WR_ADDR);
        wvalid_d    = (state_d == WR_DATA);
        wlast_d     = (state_d == WR_DATA) && (cnt_d == LAST_IDX);
        wdata_d     = line_d[wr_idx_s];
        bready_d    = (state_d == WR_RESP);
        rsp_valid_d = (state_d == RESP);
    end

    // State, datapath and output registers. An asynchronous reset aborts any burst in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= {IDX_BITS{1'b0}};
            start_q     <= {IDX_BITS{1'b0}};
            addr_q      <= {ADDR_WIDTH{1'b0}};
            line_q      <= {(DATA_WIDTH*BEATS){1'b0}};
            rsp_rdata_q <= {(DATA_WIDTH*BEATS){1'b0}};
            store_q     <= 1'b0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            wlast_q     <= 1'b0;
            wdata_q     <= {DATA_WIDTH{1'b0}};
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            start_q     <= start_d;
            addr_q      <= addr_d;
            line_q      <= line_d;
            rsp_rdata_q <= rsp_rdata_d;
            store_q     <= store_d;
            err_q       <= err_d;
            cmd_ready_q <= cmd_ready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            wlast_q     <= wlast_d;
            wdata_q     <= wdata_d;
            bready_q    <= bready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_store     = store_q;
    assign rsp_err       = err_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = 8'(BEATS - 1);
    assign m_axi_arsize  = 3'(BYTE_BITS);
    assign m_axi_arburst = (WRAP_MODE != 0) ? 2'b10 : 2'b01;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = 8'(BEATS - 1);
    assign m_axi_awsize  = 3'(BYTE_BITS);
    assign m_axi_awburst = (WRAP_MODE != 0) ? 2'b10 : 2'b01;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wlast   = wlast_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_wstrb   = {(DATA_WIDTH/8){1'b1}};
    assign m_axi_bready  = bready_q;

endmodule
